// File: rtl/lpc_pkg.sv
// Shared LPC host constants, state enumeration and the address nibble helper.
`timescale 1ns/1ps
package lpc_pkg;

   // Cycle-type field encodings and the bit positions inside in_cyctype_dir
   localparam logic [1:0] CT_IO  = 2'b00;
   localparam logic [1:0] CT_MEM = 2'b01;
   localparam int unsigned TYPE_LSB = 2;
   localparam int unsigned DIR_BIT  = 1;

   // SYNC codes returned by the target
   localparam logic [3:0] SYNC_READY      = 4'b0000;
   localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
   localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
   localparam logic [3:0] SYNC_ERROR      = 4'b1010;

   // Host-driven framing codes
   localparam logic [3:0] START_CODE = 4'b0000;
   localparam logic [3:0] ABORT_CODE = 4'b1111;
   localparam logic [3:0] TAR_CODE   = 4'b1111;

   // Phase lengths
   localparam int unsigned IO_NIBBLES  = 4;
   localparam int unsigned MEM_NIBBLES = 8;
   localparam int unsigned ABORT_CLKS  = 4;

   typedef enum logic [3:0] {
      IDLE, START, CYCTYPE, ADDR, WDATA, TAR_H, SYNC, RDATA, TAR_T, ABORT, DONE
   } lpc_state_e;

   // Select nibble idx (0 = least significant) of a 32-bit address
   function automatic logic [3:0] addr_nibble(input logic [31:0] addr, input logic [2:0] idx);
      return 4'(addr >> {idx, 2'b00});
   endfunction

endpackage

// File: rtl/lpc_host.sv
// LPC bus host: runs one I/O or memory read/write cycle per accepted request.
`timescale 1ns/1ps
module lpc_host
   import lpc_pkg::*;
#(
   parameter int unsigned SYNC_TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  in_cyctype_dir,
   input  logic [31:0] in_addr,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  lpc_ad_in,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   output logic        lpc_frame,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_error
);

   localparam int unsigned SYNC_W = $clog2(SYNC_TIMEOUT + 1);

   lpc_state_e        state_q, state_d;
   logic [2:0]        nib_q, nib_d;
   logic [SYNC_W-1:0] sync_q, sync_d;
   logic              err_q, err_d;

   logic [1:0]  req_type;
   logic        req_dir;
   logic [31:0] req_addr;
   logic [7:0]  req_data;
   logic [7:0]  rd_buf;

   logic        ready_d, frame_d, oe_d, valid_d, error_d;
   logic [3:0]  ad_d;
   logic [7:0]  data_d;

   logic        accept;
   logic [2:0]  last_nib;
   logic        unused_reserved;

   assign accept          = in_valid & in_ready;
   assign last_nib        = (req_type == CT_MEM) ? 3'(MEM_NIBBLES - 1) : 3'(IO_NIBBLES - 1);
   assign unused_reserved = in_cyctype_dir[0];

   // Next state, counters and next-cycle registered outputs
   always_comb begin
      state_d = state_q;
      nib_d   = nib_q;
      sync_d  = sync_q;
      err_d   = err_q;
      ready_d = 1'b0;
      frame_d = 1'b1;
      oe_d    = 1'b0;
      ad_d    = START_CODE;
      valid_d = 1'b0;
      error_d = 1'b0;
      data_d  = out_data;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               err_d   = 1'b0;
            end
         end
         START: begin
            state_d = CYCTYPE;
            nib_d   = 3'd0;
         end
         CYCTYPE: begin
            state_d = ADDR;
            nib_d   = 3'd0;
         end
         ADDR: begin
            if (nib_q == last_nib) begin
               state_d = req_dir ? WDATA : TAR_H;
               nib_d   = 3'd0;
            end else begin
               nib_d = nib_q + 3'd1;
            end
         end
         WDATA: begin
            if (nib_q == 3'd1) begin
               state_d = TAR_H;
               nib_d   = 3'd0;
            end else begin
               nib_d = nib_q + 3'd1;
            end
         end
         TAR_H: begin
            if (nib_q == 3'd1) begin
               state_d = SYNC;
               nib_d   = 3'd0;
               sync_d  = '0;
            end else begin
               nib_d = nib_q + 3'd1;
            end
         end
         SYNC: begin
            case (lpc_ad_in)
               SYNC_READY, SYNC_ERROR: begin
                  state_d = req_dir ? TAR_T : RDATA;
                  nib_d   = 3'd0;
                  if (lpc_ad_in == SYNC_ERROR) err_d = 1'b1;
               end
               SYNC_SHORT_WAIT, SYNC_LONG_WAIT: begin
                  state_d = SYNC;
               end
               default: begin
                  if (sync_q == SYNC_W'(SYNC_TIMEOUT - 1)) begin
                     state_d = ABORT;
                     nib_d   = 3'd0;
                     err_d   = 1'b1;
                  end else begin
                     sync_d = sync_q + SYNC_W'(1);
                  end
               end
            endcase
         end
         RDATA: begin
            if (nib_q == 3'd1) begin
               state_d = TAR_T;
               nib_d   = 3'd0;
            end else begin
               nib_d = nib_q + 3'd1;
            end
         end
         TAR_T: begin
            if (nib_q == 3'd1) begin
               state_d = DONE;
               nib_d   = 3'd0;
            end else begin
               nib_d = nib_q + 3'd1;
            end
         end
         ABORT: begin
            if (nib_q == 3'(ABORT_CLKS - 1)) begin
               state_d = DONE;
               nib_d   = 3'd0;
            end else begin
               nib_d = nib_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         IDLE:    ready_d = 1'b1;
         START: begin
            frame_d = 1'b0;
            oe_d    = 1'b1;
            ad_d    = START_CODE;
         end
         CYCTYPE: begin
            oe_d = 1'b1;
            ad_d = {req_type, req_dir, 1'b0};
         end
         ADDR: begin
            oe_d = 1'b1;
            ad_d = addr_nibble(req_addr, last_nib - nib_d);
         end
         WDATA: begin
            oe_d = 1'b1;
            ad_d = (nib_d == 3'd0) ? req_data[3:0] : req_data[7:4];
         end
         TAR_H: begin
            oe_d = (nib_d == 3'd0);
            ad_d = TAR_CODE;
         end
         ABORT: begin
            frame_d = 1'b0;
            oe_d    = 1'b1;
            ad_d    = ABORT_CODE;
         end
         DONE: begin
            valid_d = 1'b1;
            error_d = err_d;
            data_d  = req_dir ? req_data : rd_buf;
         end
         default: ;
      endcase
   end

   // State, counters and registered bus/handshake outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         nib_q      <= 3'd0;
         sync_q     <= '0;
         err_q      <= 1'b0;
         in_ready   <= 1'b1;
         lpc_frame  <= 1'b1;
         lpc_ad_oe  <= 1'b0;
         lpc_ad_out <= START_CODE;
         out_valid  <= 1'b0;
         out_error  <= 1'b0;
         out_data   <= 8'h00;
      end else begin
         state_q    <= state_d;
         nib_q      <= nib_d;
         sync_q     <= sync_d;
         err_q      <= err_d;
         in_ready   <= ready_d;
         lpc_frame  <= frame_d;
         lpc_ad_oe  <= oe_d;
         lpc_ad_out <= ad_d;
         out_valid  <= valid_d;
         out_error  <= error_d;
         out_data   <= data_d;
      end
   end

   // Request capture on accept and read-data nibble sampling
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_type <= CT_IO;
         req_dir  <= 1'b0;
         req_addr <= 32'h0;
         req_data <= 8'h00;
         rd_buf   <= 8'h00;
      end else if (accept) begin
         req_type <= in_cyctype_dir[TYPE_LSB +: 2];
         req_dir  <= in_cyctype_dir[DIR_BIT];
         req_addr <= in_addr;
         req_data <= in_data;
         rd_buf   <= 8'h00;
      end else if (state_q == RDATA) begin
         if (nib_q == 3'd0) rd_buf[3:0] <= lpc_ad_in;
         else               rd_buf[7:4] <= lpc_ad_in;
      end
   end

endmodule

// File: tb/tb_lpc_host.sv
// Self-checking bench for lpc_host: phase-list bus model plus scripted target.
`timescale 1ns/1ps
module tb_lpc_host;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  in_cyctype_dir = 4'h0;
   logic [31:0] in_addr = 32'h0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  lpc_ad_in = 4'hF;
   logic [3:0]  lpc_ad_out;
   logic        lpc_ad_oe;
   logic        lpc_frame;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_error;

   int errors = 0;
   int checks = 0;

   bit         exp_frame[$];
   bit         exp_oe[$];
   logic [3:0] exp_lad[$];
   logic [7:0] last_data;
   bit         data_known;

   lpc_host #(.SYNC_TIMEOUT(64)) dut (
      .clock(clock),
      .reset(reset),
      .in_cyctype_dir(in_cyctype_dir),
      .in_addr(in_addr),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .lpc_ad_in(lpc_ad_in),
      .lpc_ad_out(lpc_ad_out),
      .lpc_ad_oe(lpc_ad_oe),
      .lpc_frame(lpc_frame),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_error(out_error)
   );

   always #5 clock = ~clock;

   task automatic expect_cycle(input bit f, input bit oe, input logic [3:0] lad);
      exp_frame.push_back(f);
      exp_oe.push_back(oe);
      exp_lad.push_back(lad);
   endtask

   // mode: 0 = target syncs ready, 1 = target syncs error, 2 = target never syncs (tcode)
   task automatic run_txn(input string name, input bit mem, input bit wr, input bit res,
                          input logic [31:0] addr, input logic [7:0] data, input int waits,
                          input bit wrand, input int mode, input logic [3:0] tcode,
                          input logic [7:0] rdata);
      int n;
      int s;
      int sync_len;
      int d;
      logic [31:0] sh;
      logic [3:0]  drv;
      bit          exp_err;
      logic [7:0]  exp_data;
      bit          chk_data;

      exp_frame.delete();
      exp_oe.delete();
      exp_lad.delete();
      n = mem ? 8 : 4;
      expect_cycle(1'b0, 1'b1, 4'h0);
      expect_cycle(1'b1, 1'b1, {mem ? 2'b01 : 2'b00, wr, 1'b0});
      for (int i = 0; i < n; i++) begin
         sh = addr >> (4 * (n - 1 - i));
         expect_cycle(1'b1, 1'b1, sh[3:0]);
      end
      if (wr) begin
         expect_cycle(1'b1, 1'b1, data[3:0]);
         expect_cycle(1'b1, 1'b1, data[7:4]);
      end
      expect_cycle(1'b1, 1'b1, 4'hF);
      expect_cycle(1'b1, 1'b0, 4'h0);
      s = exp_frame.size() + 1;
      if (mode == 2) begin
         sync_len = 64;
         for (int i = 0; i < sync_len; i++) expect_cycle(1'b1, 1'b0, 4'h0);
         for (int i = 0; i < 4; i++) expect_cycle(1'b0, 1'b1, 4'hF);
         exp_err = 1'b1;
      end else begin
         sync_len = waits + 1;
         for (int i = 0; i < sync_len; i++) expect_cycle(1'b1, 1'b0, 4'h0);
         if (!wr) begin
            expect_cycle(1'b1, 1'b0, 4'h0);
            expect_cycle(1'b1, 1'b0, 4'h0);
         end
         expect_cycle(1'b1, 1'b0, 4'h0);
         expect_cycle(1'b1, 1'b0, 4'h0);
         exp_err = (mode == 1);
      end
      d = exp_frame.size() + 1;
      exp_data = wr ? data : rdata;
      chk_data = wr || (mode != 2);

      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_accept: got %b want 1", name, in_ready);
      end
      in_cyctype_dir = {mem ? 2'b01 : 2'b00, wr, res};
      in_addr = addr;
      in_data = data;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_addr = $urandom;
      in_data = 8'($urandom);
      in_cyctype_dir = 4'($urandom);

      for (int k = 1; k <= d + 1; k++) begin
         @(negedge clock);
         if (k >= s && k < s + sync_len) begin
            if (mode == 2) drv = tcode;
            else if (k < s + waits) drv = (wrand && ($urandom_range(0, 1) == 0)) ? 4'h5 : 4'h6;
            else drv = (mode == 1) ? 4'hA : 4'h0;
         end else if (!wr && mode != 2 && k == s + sync_len) begin
            drv = rdata[3:0];
         end else if (!wr && mode != 2 && k == s + sync_len + 1) begin
            drv = rdata[7:4];
         end else begin
            drv = 4'($urandom);
         end
         lpc_ad_in = drv;

         if (k < d) begin
            checks++;
            if (lpc_frame !== exp_frame[k-1]) begin
               errors++;
               $display("FAIL %s frame cyc %0d: got %b want %b", name, k, lpc_frame, exp_frame[k-1]);
            end
            checks++;
            if (lpc_ad_oe !== exp_oe[k-1]) begin
               errors++;
               $display("FAIL %s oe cyc %0d: got %b want %b", name, k, lpc_ad_oe, exp_oe[k-1]);
            end
            if (exp_oe[k-1]) begin
               checks++;
               if (lpc_ad_out !== exp_lad[k-1]) begin
                  errors++;
                  $display("FAIL %s lad cyc %0d: got %h want %h", name, k, lpc_ad_out, exp_lad[k-1]);
               end
            end
         end
         checks++;
         if (out_valid !== (k == d)) begin
            errors++;
            $display("FAIL %s out_valid cyc %0d: got %b want %b", name, k, out_valid, (k == d));
         end
         checks++;
         if (in_ready !== (k == d + 1)) begin
            errors++;
            $display("FAIL %s in_ready cyc %0d: got %b want %b", name, k, in_ready, (k == d + 1));
         end
         if (k == d) begin
            checks++;
            if (out_error !== exp_err) begin
               errors++;
               $display("FAIL %s out_error: got %b want %b", name, out_error, exp_err);
            end
            if (chk_data) begin
               checks++;
               if (out_data !== exp_data) begin
                  errors++;
                  $display("FAIL %s out_data: got %h want %h", name, out_data, exp_data);
               end
               last_data = exp_data;
               data_known = 1'b1;
            end else begin
               data_known = 1'b0;
            end
         end else if (data_known) begin
            checks++;
            if (out_data !== last_data) begin
               errors++;
               $display("FAIL %s out_data_hold cyc %0d: got %h want %h", name, k, out_data, last_data);
            end
         end
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #11;
      checks++;
      if ({lpc_frame, lpc_ad_oe, lpc_ad_out, out_valid, out_error, out_data} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_outputs: got frame=%b oe=%b lad=%h v=%b e=%b d=%h want 1 0 0 0 0 00",
                  lpc_frame, lpc_ad_oe, lpc_ad_out, out_valid, out_error, out_data);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      last_data = 8'h00;
      data_known = 1'b1;
   endtask

   task automatic test_directed();
      run_txn("io_write_0080", 1'b0, 1'b1, 1'b0, 32'h0000_0080, 8'hA5, 0, 1'b0, 0, 4'h0, 8'h00);
      run_txn("io_read_0060", 1'b0, 1'b0, 1'b0, 32'h0000_0060, 8'h00, 0, 1'b0, 0, 4'h0, 8'hC3);
      run_txn("mem_read_waits", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 8'h00, 3, 1'b0, 0, 4'h0, 8'h7E);
      run_txn("io_read_timeout", 1'b0, 1'b0, 1'b0, 32'h0000_1234, 8'h00, 0, 1'b0, 2, 4'hF, 8'h00);
      run_txn("io_write_syncerr", 1'b0, 1'b1, 1'b0, 32'h0000_02F8, 8'h3C, 0, 1'b0, 1, 4'h0, 8'h00);
   endtask

   task automatic test_reset_mid_addr();
      @(negedge clock);
      in_cyctype_dir = 4'b0000;
      in_addr = 32'h0000_0070;
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if (lpc_ad_oe !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_in_addr_oe: got %b want 1", lpc_ad_oe);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({lpc_frame, lpc_ad_oe, out_valid, lpc_ad_out} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL mid_reset_outputs: got frame=%b oe=%b v=%b lad=%h want 1 0 0 0",
                  lpc_frame, lpc_ad_oe, out_valid, lpc_ad_out);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      last_data = 8'h00;
      data_known = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clock);
         lpc_ad_in = 4'h0;
         checks++;
         if ({out_valid, lpc_frame, lpc_ad_oe, in_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL post_reset_idle cyc %0d: got v/frame/oe/ready=%b want 0101", k,
                     {out_valid, lpc_frame, lpc_ad_oe, in_ready});
         end
      end
      run_txn("after_reset_io_read", 1'b0, 1'b0, 1'b0, 32'h0000_0071, 8'h00, 1, 1'b1, 0, 4'h0, 8'h5A);
   endtask

   task automatic test_random();
      for (int t = 0; t < 14; t++) begin
         run_txn("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 8'($urandom), int'($urandom_range(0, 3)), 1'b1,
                 int'($urandom_range(0, 1)), 4'h0, 8'($urandom));
      end
      run_txn("random_timeout", 1'b1, 1'($urandom_range(0, 1)), 1'b0, $urandom, 8'($urandom), 0, 1'b0,
              2, 4'($urandom_range(1, 4)), 8'h00);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_addr();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 Parameter SYNC_TIMEOUT, default 64, max clocks spent in SYNC before abort.
REQ-002 clock  input  1  LPC clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_cyctype_dir  input  4  [3:2] type (00 I/O, 01 memory), [1] dir (0 read, 1 write), [0] reserved, driven as 0 on bus.
REQ-005 in_addr  input  32  cycle address; I/O uses [15:0].
REQ-006 in_data  input  8  write data.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted when in_valid and in_ready are high on the same edge.
REQ-009 lpc_ad_in  input  4  sampled LAD[3:0].
REQ-010 lpc_ad_out  output  4  driven LAD[3:0].
REQ-011 lpc_ad_oe  output  1  LAD output enable.
REQ-012 lpc_frame  output  1  LFRAME#, active low.
REQ-013 out_data  output  8  read data, or write data echo for write cycles.
REQ-014 out_valid  output  1  one-clock completion pulse.
REQ-015 out_error  output  1  qualifies out_valid: SYNC error, timeout or abort.

Function
REQ-016 States: IDLE, START, CYCTYPE, ADDR, WDATA, TAR_H, SYNC, RDATA, TAR_T, ABORT, DONE.
REQ-017 IDLE: in_ready=1, lpc_frame=1, lpc_ad_oe=0; on accept, latch all inputs and go to START.
REQ-018 in_ready is 0 in every state except IDLE, so no new request is accepted mid-cycle.
REQ-019 START (1 clk): lpc_frame=0, lpc_ad_out=0000, oe=1.
REQ-020 CYCTYPE (1 clk): lpc_frame=1, lpc_ad_out={type,dir,0}.
REQ-021 ADDR: 4 nibbles for I/O or 8 for memory, MSB nibble first; a nibble counter selects the nibble.
REQ-022 WDATA (writes only): 2 clks, low nibble then high nibble.
REQ-023 TAR_H: clk1 drives 1111 with oe=1; clk2 has oe=0.
REQ-024 SYNC, each clk with oe=0:
  - 0000 means ready, go to RDATA (read) or TAR_T (write).
  - 1010 means error: proceed exactly as 0000 and set the error flag.
  - 0101 or 0110 means wait: remain in SYNC.
  - Any other value counts toward timeout.
REQ-025 The SYNC counter resets on entry to SYNC; reaching SYNC_TIMEOUT clks without 0000 or 1010 sets the error flag and goes to ABORT.
REQ-026 RDATA: 2 clks, sample low nibble then high nibble into out_data.
REQ-027 TAR_T: 2 clks with oe=0, then DONE.
REQ-028 ABORT: 4 clks with lpc_frame=0, lpc_ad_out=1111, oe=1, then DONE.
REQ-029 DONE (1 clk): out_valid=1, out_error=flag, then IDLE; the flag clears on the next accept.
REQ-030 Clocks from accept edge to out_valid with immediate sync:
  - I/O read or write: 14.
  - Memory read or write: 18.
  - Each wait-SYNC clock adds 1.
REQ-031 out_data holds its value until the next DONE.

Reset
REQ-032 Reset, including mid-cycle, forces IDLE at once: lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=0000, out_valid=0, out_error=0, out_data=00, in_ready=1 once reset is released, counters and error flag cleared.
REQ-033 No bus cycle or completion resumes after reset release.

Structure
REQ-034 Shared package lpc_pkg holds:
  - cycle-type constants (IO=00, MEM=01) and the dir bit position;
  - SYNC codes (READY 0000, SHORT_WAIT 0101, LONG_WAIT 0110, ERROR 1010);
  - START code 0000 and ABORT code 1111;
  - the state enumeration.
REQ-035 Single module, no sub-module; the nibble and SYNC counters are inline.

Verification
REQ-036 I/O write addr 0x0080, data 0xA5, target syncs 0000 immediately:
  - LAD sequence 0000,0010,0,0,8,0,5,A,F, then target-owned clocks.
  - out_valid 14 clks after accept, out_error=0.
REQ-037 I/O read addr 0x0060, target returns SYNC 0000 then nibbles 3,C -> out_data=0xC3, out_error=0.
REQ-038 Memory read addr 0xFFFFFFF0 with three 0110 waits before 0000, data 0x7E:
  - eight address nibbles F,F,F,F,F,F,F,0.
  - out_valid 21 clks after accept, out_data=0x7E.
REQ-039 I/O read where the target leaves LAD at 1111 -> after 64 SYNC clks, 4 ABORT clks (lpc_frame=0, LAD 1111), then out_valid with out_error=1.
REQ-040 I/O write with SYNC 1010 -> normal TAR_T, then out_error=1.
REQ-041 Reset asserted during ADDR -> same cycle: lpc_frame=1, oe=0; after release, in_ready=1 and a new request completes normally.
